mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle core between two requesters: instruction fetch (IF) and data load/store (DM).
- Sits between the core's control/datapath and external memory.
- Data has priority; IF is protected by an anti-starvation wait counter.
- Downstream memory has a variable latency and a req/ack handshake. The block holds the bus until ack and returns the response to the owner.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive IF-stalled cycles after which IF beats DM; range 1..15.
- TIMEOUT_CYCLES, 64, busy cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- i_if_req  in  1  fetch request; held until o_if_gnt.
- i_if_addr  in  ADDR_W  fetch address.
- o_if_gnt  out  1  fetch accepted this cycle.
- o_if_rvalid  out  1  fetch response pulse.
- o_if_rdata  out  DATA_W  fetch read data.
- i_dm_req  in  1  data request; held until o_dm_gnt.
- i_dm_we  in  1  1 = store, 0 = load.
- i_dm_addr  in  ADDR_W  data address.
- i_dm_wdata  in  DATA_W  store data.
- o_dm_gnt  out  1  data request accepted this cycle.
- o_dm_rvalid  out  1  data completion pulse (loads and stores).
- o_dm_rdata  out  DATA_W  load data; 0 for stores.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_ack  in  1  memory completion, single-cycle pulse.
- i_mem_rdata  in  DATA_W  valid when i_mem_ack = 1.
- o_err  out  1  timeout abort pulse, accompanies rvalid.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; wait counter 0. All outputs are 0: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, both rvalid, both rdata, o_err, o_busy. gnt outputs are 0 combinationally while rst = 1.
- States:
  - IDLE: arbitrate.
  - BUSY_IF / BUSY_DM: o_mem_req = 1 until ack.
- IDLE arbitration (combinational gnt, same cycle as req):
  - if i_if_req and wait_cnt >= MAX_WAIT -> grant IF;
  - else if i_dm_req -> grant DM;
  - else if i_if_req -> grant IF;
  - else stay IDLE.
- On grant: latch addr/we/wdata into the o_mem_* registers (we = 0 for IF). Next state is BUSY_IF or BUSY_DM. o_mem_req rises the cycle after gnt.
- gnt is never asserted outside IDLE.
- BUSY_x:
  - o_mem_* held stable.
  - On i_mem_ack: next cycle o_mem_req = 0 and state = IDLE.
  - Owner's rvalid = 1 for exactly one cycle (the cycle after ack).
  - rdata is registered from i_mem_rdata for loads/fetches, 0 for stores.
- Latency: gnt at cycle T, mem_req from T+1, ack at T+k (k >= 1), rvalid at T+k+1. A new grant is possible in the same cycle T+k+1 (back-to-back).
- Wait counter (4-bit):
  - +1 each cycle i_if_req = 1 and o_if_gnt = 0; saturates at 15.
  - Cleared on IF grant, and when i_if_req = 0.
- i_mem_ack in IDLE: ignored. No rvalid, no state change.
- Simultaneous i_if_req and i_dm_req with wait_cnt < MAX_WAIT: DM wins; IF stall is counted.
- rdata outputs hold their last value when rvalid = 0.
- Reset mid-transaction: next cycle is IDLE with o_mem_req = 0, and no rvalid is generated. An ack arriving after reset is ignored.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - Busy counter clears on entry to BUSY_x and counts each busy cycle.
  - If it reaches TIMEOUT_CYCLES with no ack: abort.
  - Next cycle: state IDLE, o_mem_req = 0, owner rvalid = 1, o_err = 1, rdata = 0.
  - An ack in the same cycle as the timeout wins (normal completion, o_err = 0).
- Undefined: no busy counter; the block waits indefinitely; o_err tied 0.

Decomposition:
- Package mem_arb_pkg:
  - t_arb_state enum (IDLE = 2'b00, BUSY_IF = 2'b01, BUSY_DM = 2'b10);
  - t_owner enum (OWN_IF, OWN_DM);
  - WAIT_CNT_W = 4 constant.
- Sub-module arb_wait_counter: saturating counter with inc/clr inputs and width parameter. Instantiated for the starvation counter, and for the timeout counter when the macro is defined.

Test Plan:
- Single IF fetch:
  - Stimulus: IF req addr 0x0000_0010; memory acks 3 cycles after mem_req; i_mem_rdata 0x0000_0093.
  - Required: gnt at T, mem_req at T+1..T+3, o_if_rvalid at T+4 with rdata 0x93, mem_req = 0 at T+4.
- Simultaneous requests:
  - Stimulus: IF and DM req at the same cycle; DM load 0x100.
  - Required: DM granted first; IF granted in the cycle DM's rvalid pulses; wait_cnt back to 0 after IF grant.
- Starvation guard:
  - Stimulus: DM req held continuously (new request each grant), MAX_WAIT = 4, IF req held, ack latency 1.
  - Required: IF granted once wait_cnt reaches 4; never more than 4 IF stall cycles before the IF grant.
- Store:
  - Stimulus: DM store addr 0x200, wdata 0xDEADBEEF.
  - Required: o_mem_we = 1, o_mem_wdata = 0xDEADBEEF stable until ack; o_dm_rvalid pulse with rdata 0.
- Reset mid-transaction, stray ack:
  - Stimulus: rst asserted in BUSY_DM; ack arrives 2 cycles after rst deasserts; later, ack pulsed while idle.
  - Required: state IDLE and mem_req = 0 the cycle after rst; no rvalid for either ack.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8):
  - Stimulus: IF request, no ack.
  - Required: abort after 8 busy cycles; o_if_rvalid and o_err pulse together, rdata 0, o_busy = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } t_arb_state;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } t_owner;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module arb_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Optional abort-on-timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_WAIT       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_err,
  output logic              o_busy
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_port_arbiter: parameter out of range");
  end

  t_arb_state            state;
  t_arb_state            state_next;
  t_owner                owner;
  logic                  if_gnt;
  logic                  dm_gnt;
  logic                  done;
  logic                  abort;
  logic                  timeout;
  logic                  busy;
  logic                  starved;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rvalid_q;
  logic              dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              err_q;

  assign busy    = (state != IDLE);
  assign starved = (wait_cnt >= WAIT_CNT_W'(MAX_WAIT));

  // Fetch starvation counter: counts stalled fetch cycles, cleared on grant or drop.
  arb_wait_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (i_if_req && !if_gnt),
    .clr (!i_if_req || if_gnt),
    .cnt (wait_cnt)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned BUSY_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [BUSY_W-1:0] busy_cnt;

  // Held at zero while idle so every transaction starts its budget from zero.
  arb_wait_counter #(.W(BUSY_W)) u_busy_cnt (
    .clk (clk),
    .rst (rst),
    .inc (busy),
    .clr (!busy),
    .cnt (busy_cnt)
  );

  assign timeout = busy && (busy_cnt == BUSY_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    owner = (state == BUSY_DM) ? OWN_DM : OWN_IF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants are combinational and only issued from IDLE; an ack beats a timeout.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (i_if_req && starved) begin
            if_gnt     = 1'b1;
            state_next = BUSY_IF;
          end else if (i_dm_req) begin
            dm_gnt     = 1'b1;
            state_next = BUSY_DM;
          end else if (i_if_req) begin
            if_gnt     = 1'b1;
            state_next = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (i_mem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if (if_gnt) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= i_if_addr;
        mem_wdata_q <= '0;
      end else if (dm_gnt) begin
        mem_we_q    <= i_dm_we;
        mem_addr_q  <= i_dm_addr;
        mem_wdata_q <= i_dm_wdata;
      end
      // Completion or abort returns a response to whoever owns the bus.
      if (done || abort) begin
        err_q <= abort;
        if (owner == OWN_IF) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= abort ? '0 : i_mem_rdata;
        end else begin
          dm_rvalid_q <= 1'b1;
          dm_rdata_q  <= (abort || mem_we_q) ? '0 : i_mem_rdata;
        end
      end
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_dm_gnt    = dm_gnt;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_dm_rvalid = dm_rvalid_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_mem_req   = busy;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_err       = err_q;
  assign o_busy      = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, scoreboard-checked bench for mem_port_arbiter; timeout case runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned TO_CYC   = 8;

  typedef struct {
    logic        dm;
    logic [31:0] rdata;
    logic        err;
  } t_exp;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic        o_dm_gnt;
  logic        o_dm_rvalid;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        o_err;
  logic        o_busy;
  logic        mdl_ack;
  logic        man_ack;
  wire         mem_ack = mdl_ack | man_ack;

  int   errors = 0;
  int   checks = 0;
  t_exp sb[$];
  t_exp e;
  logic resp_en;
  logic expect_abort;
  logic hold_dm;
  int   ack_lat;
  int   lat_cnt;
  logic g_if, g_dm, rv_dm;
  int   stall;
  int   stall_at_gnt;
  int   n;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid),
    .o_dm_rdata(o_dm_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'h0000_0083;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks ack_lat cycles into each request with address-derived data.
  always @(negedge clk) begin
    mdl_ack = 1'b0;
    if (resp_en && o_mem_req && !rst) begin
      lat_cnt++;
      if (lat_cnt == ack_lat) begin
        mdl_ack     = 1'b1;
        i_mem_rdata = rd_fn(o_mem_addr);
        lat_cnt     = 0;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // Scoreboard: push on grant, pop and compare on each response pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_if_gnt)
        sb.push_back('{dm: 1'b0, rdata: expect_abort ? 32'h0 : rd_fn(i_if_addr), err: expect_abort});
      if (o_dm_gnt)
        sb.push_back('{dm: 1'b1, rdata: (expect_abort || i_dm_we) ? 32'h0 : rd_fn(i_dm_addr),
                       err: expect_abort});
      if (o_if_gnt || o_dm_gnt) chk("gnt_while_busy", 32'(o_busy), 32'h0);
      if (o_if_rvalid || o_dm_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'({o_if_rvalid, o_dm_rvalid}), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rsp_if_rvalid", 32'(o_if_rvalid), 32'(!e.dm));
          chk("rsp_dm_rvalid", 32'(o_dm_rvalid), 32'(e.dm));
          chk("rsp_rdata", e.dm ? o_dm_rdata : o_if_rdata, e.rdata);
          chk("rsp_err", 32'(o_err), 32'(e.err));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    g_if  = o_if_gnt;
    g_dm  = o_dm_gnt;
    rv_dm = o_dm_rvalid;
    if (i_if_req && !o_if_gnt) stall++;
    if (o_if_gnt) begin
      stall_at_gnt = stall;
      stall        = 0;
    end
    if (!i_if_req) stall = 0;
    @(posedge clk);
    #1;
    if (g_if) i_if_req = 1'b0;
    if (g_dm) begin
      if (hold_dm) i_dm_addr = i_dm_addr + 32'd4;
      else         i_dm_req  = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((i_if_req || i_dm_req || o_busy || sb.size() != 0) && k < 50) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 50), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_if_req = 1'b1; i_dm_req = 1'b1; i_if_addr = 32'h0; i_dm_we = 1'b0;
    i_dm_addr = 32'h0; i_dm_wdata = 32'h0; i_mem_rdata = 32'h0; mdl_ack = 1'b0; man_ack = 1'b0;
    resp_en = 1'b1; expect_abort = 1'b0; hold_dm = 1'b0; ack_lat = 3; lat_cnt = 0;
    stall = 0; stall_at_gnt = 0; g_if = 1'b0; g_dm = 1'b0; rv_dm = 1'b0;

    // Reset state, with both requests asserted during reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", 32'(o_if_gnt), 32'h0);
    chk("rst_dm_gnt", 32'(o_dm_gnt), 32'h0);
    chk("rst_mem_req", 32'(o_mem_req), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_outs", 32'({o_mem_we, o_if_rvalid, o_dm_rvalid, o_err}), 32'h0);
    chk("rst_rdata", o_if_rdata | o_dm_rdata | o_mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; i_if_req = 1'b0; i_dm_req = 1'b0;
    @(posedge clk); #1;

    // Single fetch, ack 3 cycles into the request
    ack_lat = 3; i_if_req = 1'b1; i_if_addr = 32'h0000_0010;
    @(negedge clk);
    chk("f_if_gnt", 32'(o_if_gnt), 32'h1);
    chk("f_dm_gnt", 32'(o_dm_gnt), 32'h0);
    @(posedge clk); #1 i_if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("f_mem_req", 32'(o_mem_req), 32'h1);
      chk("f_mem_addr", o_mem_addr, 32'h10);
      chk("f_mem_we", 32'(o_mem_we), 32'h0);
      chk("f_no_rvalid", 32'(o_if_rvalid), 32'h0);
    end
    @(negedge clk);
    chk("f_mem_req_low", 32'(o_mem_req), 32'h0);
    chk("f_if_rvalid", 32'(o_if_rvalid), 32'h1);
    chk("f_if_rdata", o_if_rdata, 32'h93);
    @(negedge clk);
    chk("f_rvalid_pulse", 32'(o_if_rvalid), 32'h0);
    chk("f_rdata_hold", o_if_rdata, 32'h93);
    @(posedge clk); #1;

    // Simultaneous requests: data first, fetch granted as data completes
    ack_lat = 2;
    i_if_req = 1'b1; i_if_addr = 32'h40;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h100;
    step();
    chk("sim_dm_first", 32'({g_if, g_dm}), 32'h1);
    n = 0;
    while (!g_if && n < 20) begin
      step();
      n++;
    end
    chk("sim_if_granted", 32'(g_if), 32'h1);
    chk("sim_if_at_dm_rvalid", 32'(rv_dm), 32'h1);
    chk("sim_wait_cnt_clr", 32'(dut.wait_cnt), 32'h0);
    drain("sim_drain");

    // Starvation guard: continuous data traffic, fetch must win after MAX_WAIT stalls
    ack_lat = 1; hold_dm = 1'b1; stall = 0;
    i_if_req = 1'b1; i_if_addr = 32'h80;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h1000;
    n = 0;
    g_if = 1'b0;
    while (!g_if && n < 30) begin
      step();
      n++;
    end
    chk("starve_if_granted", 32'(g_if), 32'h1);
    chk("starve_stalls", 32'(stall_at_gnt), 32'(MAX_WAIT));
    hold_dm = 1'b0;
    drain("starve_drain");

    // Store: write data held until ack, completion returns zero data
    ack_lat = 4;
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h200; i_dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_dm_gnt", 32'(o_dm_gnt), 32'h1);
    @(posedge clk); #1;
    i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("st_mem_req", 32'(o_mem_req), 32'h1);
      chk("st_mem_we", 32'(o_mem_we), 32'h1);
      chk("st_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
      chk("st_mem_addr", o_mem_addr, 32'h200);
    end
    @(negedge clk);
    chk("st_dm_rvalid", 32'(o_dm_rvalid), 32'h1);
    chk("st_dm_rdata", o_dm_rdata, 32'h0);
    drain("st_drain");

    // Reset in the middle of a data transaction, then stray acks
    resp_en = 1'b0;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h300;
    @(negedge clk);
    chk("rm_dm_gnt", 32'(o_dm_gnt), 32'h1);
    @(posedge clk); #1 i_dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rm_mem_req", 32'(o_mem_req), 32'h0);
    chk("rm_busy", 32'(o_busy), 32'h0);
    chk("rm_no_rvalid", 32'({o_if_rvalid, o_dm_rvalid}), 32'h0);
    chk("rm_dm_rdata", o_dm_rdata, 32'h0);
    @(posedge clk); #1 man_ack = 1'b1;
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    chk("rm_late_ack_rvalid", 32'({o_if_rvalid, o_dm_rvalid}), 32'h0);
    chk("rm_late_ack_busy", 32'(o_busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 man_ack = 1'b1;
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_rvalid", 32'({o_if_rvalid, o_dm_rvalid, o_err}), 32'h0);
    chk("idle_ack_busy", 32'(o_busy), 32'h0);
    @(posedge clk); #1;

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: fetch never acked, aborted after TO_CYC busy cycles
    expect_abort = 1'b1;
    i_if_req = 1'b1; i_if_addr = 32'h500;
    @(negedge clk);
    chk("to_if_gnt", 32'(o_if_gnt), 32'h1);
    @(posedge clk); #1 i_if_req = 1'b0;
    for (int k = 0; k < int'(TO_CYC); k++) begin
      @(negedge clk);
      chk("to_mem_req", 32'(o_mem_req), 32'h1);
      chk("to_no_err", 32'(o_err), 32'h0);
    end
    @(negedge clk);
    chk("to_if_rvalid", 32'(o_if_rvalid), 32'h1);
    chk("to_err", 32'(o_err), 32'h1);
    chk("to_rdata", o_if_rdata, 32'h0);
    chk("to_busy", 32'(o_busy), 32'h0);
    @(posedge clk); #1 expect_abort = 1'b0;
`endif

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
